// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Address validity is the one rule every port agrees on.
package regfile_pkg;

    localparam int MAX_RD_PORTS = 4;

    function automatic logic addr_valid(
        input int unsigned addr,
        input int unsigned depth,
        input logic        zero_reg
    );
        return (addr < depth) && !(zero_reg && addr == 0);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: range check, write bypass, busy select.
// Bypassed reads report not-busy because the producer is retiring now.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_wr_vld0,
    input  logic [ADDR_W-1:0] i_wr_addr0,
    input  logic [DATA_W-1:0] i_wr_data0,
    input  logic              i_wr_vld1,
    input  logic [ADDR_W-1:0] i_wr_addr1,
    input  logic [DATA_W-1:0] i_wr_data1,
    input  logic [DATA_W-1:0] i_mem [DEPTH],
    input  logic [DEPTH-1:0]  i_busy,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy
);

    logic w_valid;
    logic w_hit0;
    logic w_hit1;

    assign w_valid = addr_valid(32'(i_addr), DEPTH, ZERO_REG != 0);
    assign w_hit0  = (BYPASS != 0) && i_wr_vld0 && (i_wr_addr0 == i_addr);
    assign w_hit1  = (BYPASS != 0) && i_wr_vld1 && (i_wr_addr1 == i_addr);

    always_comb begin
        o_data = '0;
        o_busy = 1'b0;
        if (w_hit1) begin
            o_data = i_wr_data1;
        end else if (w_hit0) begin
            o_data = i_wr_data0;
        end else if (w_valid) begin
            o_data = i_mem[i_addr];
            o_busy = i_busy[i_addr];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: two prioritised write ports, N read ports,
// optional bypass and zero register, plus a per-register busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 16,
    parameter int RD_PORTS = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wrEn0,
    input  logic [ADDR_W-1:0]            wrAddr0,
    input  logic [DATA_W-1:0]            wrData0,
    input  logic                         wrEn1,
    input  logic [ADDR_W-1:0]            wrAddr1,
    input  logic [DATA_W-1:0]            wrData1,
    input  logic [RD_PORTS*ADDR_W-1:0]   rdAddr,
    output logic [RD_PORTS*DATA_W-1:0]   rdData,
    output logic [RD_PORTS-1:0]          rdBusy,
    input  logic                         setBusy,
    input  logic [ADDR_W-1:0]            setBusyAddr
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic              w_wv0;
    logic              w_wv1;
    logic              w_set;

    // Gating with reset_n keeps bypassed reads at zero while in reset.
    assign w_wv0 = reset_n && wrEn0
                 && addr_valid(32'(wrAddr0), DEPTH, ZERO_REG != 0);
    assign w_wv1 = reset_n && wrEn1
                 && addr_valid(32'(wrAddr1), DEPTH, ZERO_REG != 0);
    assign w_set = setBusy
                 && addr_valid(32'(setBusyAddr), DEPTH, ZERO_REG != 0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_mem[r] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wv0) r_mem[wrAddr0] <= wrData0;
            if (w_wv1) r_mem[wrAddr1] <= wrData1;
            for (int r = 0; r < DEPTH; r++) begin
                if (w_set && setBusyAddr == ADDR_W'(r)) begin
                    r_busy[r] <= 1'b1;
                end else if ((w_wv0 && wrAddr0 == ADDR_W'(r))
                          || (w_wv1 && wrAddr1 == ADDR_W'(r))) begin
                    r_busy[r] <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < RD_PORTS && g < MAX_RD_PORTS; g++) begin : g_rd
        regfile_rdport #(
            .DATA_W  (DATA_W),
            .DEPTH   (DEPTH),
            .ADDR_W  (ADDR_W),
            .BYPASS  (BYPASS),
            .ZERO_REG(ZERO_REG)
        ) u_rd (
            .i_addr    (rdAddr[g*ADDR_W +: ADDR_W]),
            .i_wr_vld0 (w_wv0),
            .i_wr_addr0(wrAddr0),
            .i_wr_data0(wrData0),
            .i_wr_vld1 (w_wv1),
            .i_wr_addr1(wrAddr1),
            .i_wr_data1(wrData1),
            .i_mem     (r_mem),
            .i_busy    (r_busy),
            .o_data    (rdData[g*DATA_W +: DATA_W]),
            .o_busy    (rdBusy[g])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations share one stimulus stream.
// A: bypass, B: no bypass, C: zero reg, depth 12, four read ports.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wrEn0, wrEn1, setBusy;
    logic [3:0]  wrAddr0, wrAddr1, setBusyAddr;
    logic [15:0] wrData0, wrData1;
    logic [15:0] rdAddr;
    logic [31:0] dA, dB;
    logic [1:0]  bA, bB;
    logic [63:0] dC;
    logic [3:0]  bC;

    int n_checks = 0;
    int n_fail   = 0;

    int          DEP [3] = '{16, 16, 12};
    bit          BYP [3] = '{1'b1, 1'b0, 1'b1};
    bit          ZR  [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] mm  [3][16];
    logic        mb  [3][16];

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(16), .DEPTH(16), .RD_PORTS(2),
                 .BYPASS(1), .ZERO_REG(0)) u_a (
        .clk(clk), .reset_n(reset_n),
        .wrEn0(wrEn0), .wrAddr0(wrAddr0), .wrData0(wrData0),
        .wrEn1(wrEn1), .wrAddr1(wrAddr1), .wrData1(wrData1),
        .rdAddr(rdAddr[7:0]), .rdData(dA), .rdBusy(bA),
        .setBusy(setBusy), .setBusyAddr(setBusyAddr));

    regfile_mp #(.DATA_W(16), .DEPTH(16), .RD_PORTS(2),
                 .BYPASS(0), .ZERO_REG(0)) u_b (
        .clk(clk), .reset_n(reset_n),
        .wrEn0(wrEn0), .wrAddr0(wrAddr0), .wrData0(wrData0),
        .wrEn1(wrEn1), .wrAddr1(wrAddr1), .wrData1(wrData1),
        .rdAddr(rdAddr[7:0]), .rdData(dB), .rdBusy(bB),
        .setBusy(setBusy), .setBusyAddr(setBusyAddr));

    regfile_mp #(.DATA_W(16), .DEPTH(12), .RD_PORTS(4),
                 .BYPASS(1), .ZERO_REG(1)) u_c (
        .clk(clk), .reset_n(reset_n),
        .wrEn0(wrEn0), .wrAddr0(wrAddr0), .wrData0(wrData0),
        .wrEn1(wrEn1), .wrAddr1(wrAddr1), .wrData1(wrData1),
        .rdAddr(rdAddr), .rdData(dC), .rdBusy(bC),
        .setBusy(setBusy), .setBusyAddr(setBusyAddr));

    function automatic bit mvalid(int c, int a);
        return (a < DEP[c]) && !(ZR[c] && a == 0);
    endfunction

    // Expected {busy, data} of configuration c reading address a right now.
    function automatic logic [16:0] exp_rd(int c, int a);
        if (!reset_n) return '0;
        if (BYP[c] && wrEn1 && mvalid(c, int'(wrAddr1)) && int'(wrAddr1) == a)
            return {1'b0, wrData1};
        if (BYP[c] && wrEn0 && mvalid(c, int'(wrAddr0)) && int'(wrAddr0) == a)
            return {1'b0, wrData0};
        if (!mvalid(c, a)) return '0;
        return {mb[c][a], mm[c][a]};
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 16; r++) begin
                mm[c][r] = '0;
                mb[c][r] = 1'b0;
            end
    endtask

    task automatic model_edge();
        int a0, a1, sa;
        if (!reset_n) return;
        a0 = int'(wrAddr0);
        a1 = int'(wrAddr1);
        sa = int'(setBusyAddr);
        for (int c = 0; c < 3; c++) begin
            bit v0, v1;
            v0 = wrEn0 && mvalid(c, a0);
            v1 = wrEn1 && mvalid(c, a1);
            if (v0) begin mm[c][a0] = wrData0; mb[c][a0] = 1'b0; end
            if (v1) begin mm[c][a1] = wrData1; mb[c][a1] = 1'b0; end
            if (setBusy && mvalid(c, sa)) mb[c][sa] = 1'b1;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wrEn0 = 0; wrAddr0 = 0; wrData0 = 0;
        wrEn1 = 0; wrAddr1 = 0; wrData1 = 0;
        setBusy = 0; setBusyAddr = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        model_clear();
        idle();
        wrEn0 = 1; wrAddr0 = 1; wrData0 = 16'h7777;
        setBusy = 1; setBusyAddr = 1;
        rdAddr = 16'h1111;
        @(negedge clk);
        n_checks++;
        if ({dA, bA, dB, bB, dC, bC} !== '0) begin
            n_fail++;
            $display("FAIL in_reset: got A=%h B=%h C=%h want 0", dA, dB, dC);
        end
        step();
        reset_n = 1;
        idle();
        wrEn0 = 1; wrAddr0 = 3; wrData0 = 16'hBEEF;
        step();
        idle();
        rdAddr = 16'h0003;
        @(negedge clk);
        n_checks++;
        if (dA[15:0] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL pre_reset_rd: got %h want beef", dA[15:0]);
        end
        #1;
        reset_n = 0;
        model_clear();
        #1;
        n_checks++;
        if (dA[15:0] !== 16'h0 || bA !== 2'b0) begin
            n_fail++;
            $display("FAIL async_clear: got %h/%b want 0/0", dA[15:0], bA);
        end
        step();
        reset_n = 1;
        @(negedge clk);
        n_checks++;
        if (dA[15:0] !== 16'h0 || bA[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: got %h/%b want 0/0", dA[15:0], bA[0]);
        end
        wrEn0 = 1; wrAddr0 = 3; wrData0 = 16'h1234;
        step();
        idle();
        @(negedge clk);
        n_checks++;
        if (dA[15:0] !== 16'h1234) begin
            n_fail++;
            $display("FAIL wr_rd: got %h want 1234", dA[15:0]);
        end
        step();
    endtask

    task automatic test_collision();
        wrEn0 = 1; wrAddr0 = 5; wrData0 = 16'hAAAA;
        wrEn1 = 1; wrAddr1 = 5; wrData1 = 16'h5555;
        rdAddr = 16'h0005;
        @(negedge clk);
        n_checks++;
        if (dA[15:0] !== 16'h5555 || bA[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_bypass: got %h want 5555", dA[15:0]);
        end
        n_checks++;
        if (dB[15:0] !== 16'h0000) begin
            n_fail++;
            $display("FAIL coll_nobyp: got %h want 0000", dB[15:0]);
        end
        step();
        idle();
        @(negedge clk);
        n_checks++;
        if (dA[15:0] !== 16'h5555 || dB[15:0] !== 16'h5555) begin
            n_fail++;
            $display("FAIL coll_stored: got %h/%h want 5555", dA[15:0], dB[15:0]);
        end
        step();
    endtask

    task automatic test_no_bypass();
        wrEn0 = 1; wrAddr0 = 7; wrData0 = 16'h00FF;
        rdAddr = 16'h0070;
        @(negedge clk);
        n_checks++;
        if (dB[31:16] !== 16'h0000) begin
            n_fail++;
            $display("FAIL nobyp_same: got %h want 0000", dB[31:16]);
        end
        n_checks++;
        if (dA[31:16] !== 16'h00FF) begin
            n_fail++;
            $display("FAIL byp_same: got %h want 00ff", dA[31:16]);
        end
        step();
        idle();
        @(negedge clk);
        n_checks++;
        if (dB[31:16] !== 16'h00FF) begin
            n_fail++;
            $display("FAIL nobyp_next: got %h want 00ff", dB[31:16]);
        end
        step();
    endtask

    task automatic test_scoreboard();
        setBusy = 1; setBusyAddr = 2;
        rdAddr = 16'h0002;
        @(negedge clk);
        n_checks++;
        if (bA[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_early: got %b want 0", bA[0]);
        end
        step();
        idle();
        @(negedge clk);
        n_checks++;
        if (bA[0] !== 1'b1 || bB[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_set: got %b/%b want 1/1", bA[0], bB[0]);
        end
        wrEn0 = 1; wrAddr0 = 2; wrData0 = 16'h1111;
        #1;
        n_checks++;
        if (bA[0] !== 1'b0 || bB[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_byp: got %b/%b want 0/1", bA[0], bB[0]);
        end
        step();
        idle();
        @(negedge clk);
        n_checks++;
        if (bA[0] !== 1'b0 || bB[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_clr: got %b/%b want 0/0", bA[0], bB[0]);
        end
        setBusy = 1; setBusyAddr = 2;
        wrEn0 = 1; wrAddr0 = 2; wrData0 = 16'h2222;
        step();
        idle();
        @(negedge clk);
        n_checks++;
        if (bB[0] !== 1'b1 || bA[0] !== 1'b1 || dB[15:0] !== 16'h2222) begin
            n_fail++;
            $display("FAIL set_wins: got %b/%b/%h want 1/1/2222",
                     bA[0], bB[0], dB[15:0]);
        end
        step();
    endtask

    task automatic test_zero_range();
        logic [16:0] e;
        wrEn0 = 1; wrAddr0 = 0; wrData0 = 16'hFFFF;
        rdAddr = 16'h0000;
        @(negedge clk);
        n_checks++;
        if (dC[15:0] !== 16'h0) begin
            n_fail++;
            $display("FAIL zero_byp: got %h want 0", dC[15:0]);
        end
        step();
        idle();
        @(negedge clk);
        n_checks++;
        if (dC[15:0] !== 16'h0 || dA[15:0] !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL zero_wr: got C=%h A=%h want 0/ffff",
                     dC[15:0], dA[15:0]);
        end
        setBusy = 1; setBusyAddr = 0;
        step();
        idle();
        @(negedge clk);
        n_checks++;
        if (bC[0] !== 1'b0 || bA[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_busy: got C=%b A=%b want 0/1", bC[0], bA[0]);
        end
        wrEn0 = 1; wrAddr0 = 13; wrData0 = 16'h1357;
        setBusy = 1; setBusyAddr = 13;
        rdAddr = 16'h000D;
        @(negedge clk);
        n_checks++;
        if (dC[15:0] !== 16'h0 || bC[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_byp: got %h/%b want 0/0", dC[15:0], bC[0]);
        end
        step();
        idle();
        for (int r = 0; r < 16; r++) begin
            rdAddr = 16'(r);
            #1;
            e = exp_rd(2, r);
            n_checks++;
            if ({bC[0], dC[15:0]} !== e) begin
                n_fail++;
                $display("FAIL range_rd[%0d]: got %b/%h want %b/%h",
                         r, bC[0], dC[15:0], e[16], e[15:0]);
            end
        end
        rdAddr = 16'h000D;
        #1;
        n_checks++;
        if (dC[15:0] !== 16'h0 || bC[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_rd: got %h/%b want 0/0", dC[15:0], bC[0]);
        end
        step();
    endtask

    task automatic test_alias();
        wrEn1 = 1; wrAddr1 = 9; wrData1 = 16'hC0DE;
        setBusy = 1; setBusyAddr = 9;
        step();
        idle();
        rdAddr = 16'h9999;
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if (dC[p*16 +: 16] !== 16'hC0DE) begin
                n_fail++;
                $display("FAIL alias_d[%0d]: got %h want c0de", p, dC[p*16 +: 16]);
            end
        end
        n_checks++;
        if (bC !== 4'hF) begin
            n_fail++;
            $display("FAIL alias_busy: got %b want 1111", bC);
        end
        step();
    endtask

    task automatic test_random();
        logic [16:0] e;
        logic [15:0] ad;
        logic        ab;
        int          np;
        for (int i = 0; i < 400; i++) begin
            if (!reset_n) reset_n = 1;
            if ($urandom_range(0, 49) == 0) begin
                reset_n = 0;
                model_clear();
            end
            wrEn0 = 1'($urandom_range(0, 1));
            wrAddr0 = 4'($urandom_range(0, 15));
            wrData0 = 16'($urandom);
            wrEn1 = 1'($urandom_range(0, 1));
            wrAddr1 = ($urandom_range(0, 3) == 0) ? wrAddr0
                                                  : 4'($urandom_range(0, 15));
            wrData1 = 16'($urandom);
            setBusy = 1'($urandom_range(0, 1));
            setBusyAddr = 4'($urandom_range(0, 15));
            rdAddr = 16'($urandom);
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                np = (c == 2) ? 4 : 2;
                for (int p = 0; p < np; p++) begin
                    e = exp_rd(c, int'(rdAddr[p*4 +: 4]));
                    case (c)
                        0: begin ad = dA[p*16 +: 16]; ab = bA[p]; end
                        1: begin ad = dB[p*16 +: 16]; ab = bB[p]; end
                        default: begin ad = dC[p*16 +: 16]; ab = bC[p]; end
                    endcase
                    n_checks++;
                    if ({ab, ad} !== e) begin
                        n_fail++;
                        $display("FAIL rand[%0d] cfg%0d port%0d: got %b/%h want %b/%h",
                                 i, c, p, ab, ad, e[16], e[15:0]);
                    end
                end
            end
            step();
        end
        reset_n = 1;
        idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rdAddr = '0;
        reset_n = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_collision();
        test_no_bypass();
        test_scoreboard();
        test_zero_range();
        test_alias();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the processor datapath, replacing the fixed 16x16 two-read/one-write file. Provides:
- configurable width, depth and number of read ports;
- two write ports with fixed priority;
- optional write-to-read bypass;
- optional hardwired zero register;
- per-register busy scoreboard that the issue logic uses to detect outstanding writes.

Parameters:
DATA_W, 16, bits per register
DEPTH, 16, number of registers (2..256, need not be a power of two)
ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
RD_PORTS, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports
ZERO_REG, 0, 1 = register 0 reads 0, ignores writes, never busy

Ports:
clk  in  1  system clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
wrEn0  in  1  write port 0 enable
wrAddr0  in  ADDR_W  write port 0 address
wrData0  in  DATA_W  write port 0 data
wrEn1  in  1  write port 1 enable
wrAddr1  in  ADDR_W  write port 1 address
wrData1  in  DATA_W  write port 1 data
rdAddr  in  RD_PORTS*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rdData  out  RD_PORTS*DATA_W  packed read data, same packing
rdBusy  out  RD_PORTS  busy flag of each addressed register
setBusy  in  1  mark register setBusyAddr busy (producer issued)
setBusyAddr  in  ADDR_W  register to mark busy

Behaviour:
- Reset: reset_n low asynchronously clears all registers to 0 and all busy bits to 0.
  - rdData and rdBusy reflect the cleared state immediately: all 0 while in reset.
  - Writes and setBusy are ignored while reset_n is low.
  - Deassertion takes effect at the next rising edge.
- Write, rising edge: if wrEnK and the address is valid, reg[wrAddrK] <= wrDataK.
  - Both ports enabled to the same address: port 1 wins, port 0 is dropped.
- Valid address: below DEPTH, and not 0 when ZERO_REG=1. Any other address on a write, setBusy or clear is ignored.
- Read is combinational, zero latency.
  - rdData[i] = reg[rdAddr[i]].
  - Out-of-range address returns 0 with busy 0.
  - Address 0 with ZERO_REG=1 returns 0 with busy 0.
- Bypass (BYPASS=1):
  - If any enabled write hits rdAddr[i] in the same cycle, rdData[i] = that write's data (port 1 over port 0).
  - In that case rdBusy[i] = 0, since the write is completing.
- BYPASS=0: reads return the pre-edge register contents; new data is visible the cycle after the write.
- Busy scoreboard: one bit per register. At each rising edge, per register r:
  - set if setBusy and setBusyAddr==r;
  - else cleared if any enabled write targets r;
  - else held.
  - Set beats clear on collision, because a new producer issued in the same cycle as the old result retires.
- rdBusy[i] = busy[rdAddr[i]], subject to the bypass override above.
- No read-port count limits writes; all read ports are independent and may alias the same address.

Decomposition:
- Package regfile_pkg holds:
  - function addr_valid(addr, DEPTH, ZERO_REG);
  - localparam MAX_RD_PORTS = 4.
- One sub-module, regfile_rdport: a single read port containing the address-valid check, bypass mux and busy select. It is instantiated RD_PORTS times in a generate loop.
- The storage array and the scoreboard stay in the top module.

Test Plan:
1. Reset and basic write/read: assert reset_n=0 mid-run after writing reg3=16'hBEEF, then release and read reg3 -> 16'h0000, rdBusy=0. Write reg3=16'h1234 via port 0 and read next cycle -> 16'h1234.
2. Write collision: port0 writes reg5=16'hAAAA and port1 writes reg5=16'h5555 in the same cycle -> reg5 reads 16'h5555. Same cycle with BYPASS=1 and rdAddr[0]=5 -> rdData[0]=16'h5555 combinationally.
3. Bypass off: BYPASS=0, write reg7=16'h00FF while rdAddr[1]=7 -> same cycle shows old value 16'h0000, next cycle 16'h00FF.
4. Scoreboard: setBusy reg2 -> rdBusy=1 from the next cycle. A write to reg2 clears it one cycle later. setBusy reg2 together with a write to reg2 in the same cycle -> busy stays 1 and data is updated.
5. Zero register and range (ZERO_REG=1, DEPTH=12):
   - write reg0=16'hFFFF -> reads 0;
   - setBusy reg0 -> rdBusy 0;
   - write reg13 -> no register changes;
   - rdAddr=13 -> data 0, busy 0.
6. Port aliasing: RD_PORTS=4, all four rdAddr=9 with reg9=16'hC0DE -> all four rdData=16'hC0DE and identical rdBusy.
